// File: rtl/framer_pkg.sv
// -----------------------------------------------------------------------------
// framer_pkg
// Shared definitions for packet_framer_ctrl:
//   - framer_state_t : frame controller state encoding
//   - FRAMER_SOF_CODE / FRAMER_EOF_CODE : default start/end-of-frame words
// -----------------------------------------------------------------------------
package framer_pkg;

  localparam int unsigned FRAMER_SOF_CODE = 'h7E;
  localparam int unsigned FRAMER_EOF_CODE = 'h81;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD_SOF  = 4'd1,
    ST_SEND_SOF  = 4'd2,
    ST_WAIT_DATA = 4'd3,
    ST_LOAD_DATA = 4'd4,
    ST_SEND_DATA = 4'd5,
    ST_LOAD_CSUM = 4'd6,
    ST_SEND_CSUM = 4'd7,
    ST_LOAD_EOF  = 4'd8,
    ST_SEND_EOF  = 4'd9,
    ST_DRAIN     = 4'd10,
    ST_GAP       = 4'd11
  } framer_state_t;

endpackage

// File: rtl/packet_framer_ctrl.sv
// -----------------------------------------------------------------------------
// packet_framer_ctrl
// Transmit framer controller. On start it hands SOF, then payload words pulled
// from an upstream valid/ready source, then EOF to a serialiser, one word per
// tx_load/tx_done handshake. Payload is capped at MAX_LEN words; an overlong
// frame is closed early (truncated pulse) and the rest of the upstream packet
// is popped and discarded up to data_last. GAP_CYC idle cycles follow each
// frame before the next start is accepted.
//
// Optional build macro FRAMER_CHECKSUM_EN: inserts an XOR checksum word of the
// transmitted payload between the last payload word and EOF.
//
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   start             frame request (sampled in IDLE only)
//   data_in/valid/last, data_ready   upstream payload source (pop on valid&ready)
//   tx_done           serialiser finished current word
//   tx_load, tx_data  one-cycle load strobe and word to serialiser
//   busy              controller not in IDLE
//   truncated         one-cycle pulse when a frame is cut at MAX_LEN
//   payload_len       payload words sent in current/last frame
//   frame_cnt         completed frames (wrapping)
// -----------------------------------------------------------------------------
module packet_framer_ctrl
  import framer_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] SOF_CODE = DATA_W'(FRAMER_SOF_CODE),
  parameter logic [DATA_W-1:0] EOF_CODE = DATA_W'(FRAMER_EOF_CODE),
  parameter int                MAX_LEN  = 64,
  parameter int                GAP_CYC  = 2,
  parameter int                LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_last,
  output logic              data_ready,
  input  logic              tx_done,
  output logic              tx_load,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              truncated,
  output logic [LEN_W-1:0]  payload_len,
  output logic [15:0]       frame_cnt
);

  // Gap counter runs 0 .. GAP_CYC-1; sized to at least one bit so the
  // GAP_CYC=0 build (GAP never entered) stays well-formed.
  localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

`ifdef FRAMER_CHECKSUM_EN
  localparam framer_state_t AFTER_PAYLOAD = ST_LOAD_CSUM;
`else
  localparam framer_state_t AFTER_PAYLOAD = ST_LOAD_EOF;
`endif
  localparam framer_state_t AFTER_FRAME = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;

  framer_state_t     state_q, state_d;
  logic [DATA_W-1:0] hold_q;
  logic              last_q;
  logic              drain_q;
  logic              trunc_q;
  logic [LEN_W-1:0]  len_q;
  logic [15:0]       frame_cnt_q;
  logic [GAP_W-1:0]  gap_q;

  logic len_at_max;
  logic gap_done;

  assign len_at_max = (len_q == LEN_W'(MAX_LEN));
  assign gap_done   = (gap_q == GAP_W'(GAP_LAST));

`ifdef FRAMER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  // Accumulates exactly the words handed to the serialiser, so a truncated
  // frame carries the checksum of what was actually sent.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      csum_q <= '0;
    end else if (state_q == ST_LOAD_SOF) begin
      csum_q <= '0;
    end else if (state_q == ST_LOAD_DATA) begin
      csum_q <= csum_q ^ hold_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_ready = 1'b0;
    tx_load    = 1'b0;
    tx_data    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD_SOF;
      end
      ST_LOAD_SOF: begin
        tx_load = 1'b1;
        tx_data = SOF_CODE;
        state_d = ST_SEND_SOF;
      end
      ST_SEND_SOF: begin
        if (tx_done) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        data_ready = 1'b1;
        if (data_valid) state_d = ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        tx_load = 1'b1;
        tx_data = hold_q;
        state_d = ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        // A last word landing exactly on MAX_LEN is a normal close: last wins.
        if (tx_done) begin
          if (last_q || len_at_max) state_d = AFTER_PAYLOAD;
          else                      state_d = ST_WAIT_DATA;
        end
      end
`ifdef FRAMER_CHECKSUM_EN
      ST_LOAD_CSUM: begin
        tx_load = 1'b1;
        tx_data = csum_q;
        state_d = ST_SEND_CSUM;
      end
      ST_SEND_CSUM: begin
        if (tx_done) state_d = ST_LOAD_EOF;
      end
`endif
      ST_LOAD_EOF: begin
        tx_load = 1'b1;
        tx_data = EOF_CODE;
        state_d = ST_SEND_EOF;
      end
      ST_SEND_EOF: begin
        if (tx_done) state_d = drain_q ? ST_DRAIN : AFTER_FRAME;
      end
      ST_DRAIN: begin
        // Remainder of an overlong packet is popped and dropped.
        data_ready = 1'b1;
        if (data_valid && data_last) state_d = AFTER_FRAME;
      end
      ST_GAP: begin
        if (gap_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_q      <= '0;
      last_q      <= 1'b0;
      drain_q     <= 1'b0;
      trunc_q     <= 1'b0;
      len_q       <= '0;
      frame_cnt_q <= '0;
      gap_q       <= '0;
    end else begin
      trunc_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) len_q <= '0;
        end
        ST_WAIT_DATA: begin
          if (data_valid) begin
            hold_q <= data_in;
            last_q <= data_last;
            len_q  <= len_q + LEN_W'(1);
          end
        end
        ST_SEND_DATA: begin
          if (tx_done && !last_q && len_at_max) begin
            trunc_q <= 1'b1;
            drain_q <= 1'b1;
          end
        end
        ST_SEND_EOF: begin
          if (tx_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            gap_q       <= '0;
          end
        end
        ST_DRAIN: begin
          if (data_valid && data_last) begin
            drain_q <= 1'b0;
            gap_q   <= '0;
          end
        end
        ST_GAP: begin
          gap_q <= gap_q + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign truncated   = trunc_q;
  assign payload_len = len_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_packet_framer_ctrl.sv
module tb_packet_framer_ctrl;

  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 4;
  localparam int GAP_CYC = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [7:0] SOF = 8'h7E;
  localparam logic [7:0] EOF = 8'h81;

  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [7:0] d; logic l; } src_t;
  typedef struct {
    int         n;
    logic [7:0] w[8];
    int         exp_len;
    bit         exp_trunc;
    int         dly;
  } vec_t;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_last;
  logic              data_ready;
  logic              tx_done;
  logic              tx_load;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              truncated;
  logic [LEN_W-1:0]  payload_len;
  logic [15:0]       frame_cnt;

  packet_framer_ctrl #(
    .DATA_W (DATA_W),
    .MAX_LEN(MAX_LEN),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_last  (data_last),
    .data_ready (data_ready),
    .tx_done    (tx_done),
    .tx_load    (tx_load),
    .tx_data    (tx_data),
    .busy       (busy),
    .truncated  (truncated),
    .payload_len(payload_len),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_frames = 0;

  // ---------------- upstream source ----------------
  src_t src_q[$];
  bit   src_stall = 1'b0;
  int   src_gap_pct = 0;
  int   pops = 0;

  initial begin
    data_valid = 1'b0;
    data_in    = '0;
    data_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (src_q.size() > 0 && !src_stall && ($urandom_range(99) >= src_gap_pct)) begin
        data_valid = 1'b1;
        data_in    = src_q[0].d;
        data_last  = src_q[0].l;
      end else begin
        data_valid = 1'b0;
        data_in    = '0;
        data_last  = 1'b0;
      end
      #1;
      if (data_valid && data_ready === 1'b1 && n_rst) begin
        void'(src_q.pop_front());
        pops++;
      end
    end
  end

  // ---------------- serialiser + monitor ----------------
  int         ser_dmin = 1;
  int         ser_dmax = 1;
  bit         ser_noise = 1'b0;
  int         ser_cnt = 0;
  logic [7:0] cur_word = '0;
  logic [7:0] cap_q[$];
  int         cap_cyc_q[$];
  int         eof_done_q[$];
  int         trunc_cnt = 0;
  int         idle_data_bad = 0;

  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!n_rst) begin
        ser_cnt = 0;
      end else if (ser_cnt > 0) begin
        ser_cnt--;
        if (ser_cnt == 0) begin
          tx_done = 1'b1;
          if (cur_word == EOF) eof_done_q.push_back(cyc);
        end
      end else if (ser_noise && $urandom_range(3) == 0) begin
        tx_done = 1'b1;
      end
      if (tx_load === 1'b1) begin
        cap_q.push_back(tx_data);
        cap_cyc_q.push_back(cyc);
        cur_word = tx_data;
        ser_cnt  = $urandom_range(ser_dmax, ser_dmin);
      end else if (tx_data !== '0) begin
        idle_data_bad++;
      end
      if (truncated === 1'b1) trunc_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d, required finish)", cyc);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: what the serialiser must see for a packet of w (last on final word).
  task automatic model_frame(input bq_t w, output bq_t exp, output int len, output bit tr);
    logic [7:0] cs;
    cs  = '0;
    len = (w.size() < MAX_LEN) ? w.size() : MAX_LEN;
    tr  = (w.size() > MAX_LEN);
    exp = {};
    exp.push_back(SOF);
    for (int i = 0; i < len; i++) begin
      exp.push_back(w[i]);
      cs ^= w[i];
    end
`ifdef FRAMER_CHECKSUM_EN
    exp.push_back(cs);
`endif
    exp.push_back(EOF);
  endtask

  task automatic prep();
    cap_q.delete();
    cap_cyc_q.delete();
    eof_done_q.delete();
    trunc_cnt = 0;
    pops = 0;
  endtask

  task automatic push_src(input bq_t w);
    src_t e;
    for (int i = 0; i < w.size(); i++) begin
      e.d = w[i];
      e.l = (i == w.size() - 1);
      src_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input bit rstart, output int fall, output bit ok);
    int t;
    t = 0;
    while (busy !== 1'b1 && t < 2000) begin tick(); t++; end
    while (busy !== 1'b0 && t < 2000) begin
      if (rstart) start = 1'($urandom_range(1));
      tick();
      t++;
    end
    if (rstart) start = 1'b0;
    fall = cyc;
    ok = (busy === 1'b0) && (t < 2000);
  endtask

  task automatic cmp_seq(input string tag, input bq_t exp);
    int n;
    check({tag, ".nwords"}, cap_q.size(), exp.size());
    n = (cap_q.size() < exp.size()) ? cap_q.size() : exp.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.w%0d", tag, i), cap_q[i], exp[i]);
  endtask

  // Start already issued; waits for completion and checks the whole frame.
  task automatic finish_frame(input string tag, input bq_t w, input int exp_len,
                              input bit exp_tr, input bit rstart, output int fall);
    bq_t exp;
    int  mlen;
    bit  mtr;
    bit  ok;
    model_frame(w, exp, mlen, mtr);
    wait_idle(rstart, fall, ok);
    check({tag, ".done"}, ok, 1);
    cmp_seq(tag, exp);
    check({tag, ".payload_len"}, payload_len, exp_len);
    check({tag, ".trunc_pulses"}, trunc_cnt, exp_tr);
    check({tag, ".pops"}, pops, w.size());
    exp_frames++;
    check({tag, ".frame_cnt"}, frame_cnt, exp_frames & 'hFFFF);
    repeat (3) tick();
    check({tag, ".stays_idle"}, busy, 0);
    check({tag, ".len_hold"}, payload_len, exp_len);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- main ----------------
  vec_t vecs[6];

  initial begin
    bq_t w, w2, e1, e2, eall;
    int  fall, fall2, t, l1, l2, len;
    bit  ok, ok2, tr, hold_ok, tr1, tr2;

    vecs[0] = '{3, '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1'b0, 4};
    vecs[1] = '{6, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00}, 4, 1'b1, 2};
    vecs[2] = '{4, '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 1'b0, 1};
    vecs[3] = '{1, '{8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b0, 1};
    vecs[4] = '{5, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00}, 4, 1'b1, 3};
    vecs[5] = '{3, '{8'h0F, 8'hF0, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1'b0, 1};

    // Reset state
    repeat (3) tick();
    check("rst.busy", busy, 0);
    check("rst.tx_load", tx_load, 0);
    check("rst.tx_data", tx_data, 0);
    check("rst.data_ready", data_ready, 0);
    check("rst.truncated", truncated, 0);
    check("rst.payload_len", payload_len, 0);
    check("rst.frame_cnt", frame_cnt, 0);
    n_rst = 1'b1;
    tick();

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      w = {};
      for (int i = 0; i < vecs[v].n; i++) w.push_back(vecs[v].w[i]);
      prep();
      ser_dmin = vecs[v].dly; ser_dmax = vecs[v].dly; ser_noise = 1'b0; src_gap_pct = 0;
      push_src(w);
      pulse_start();
      finish_frame($sformatf("vec%0d", v), w, vecs[v].exp_len, vecs[v].exp_trunc, 1'b0, fall);
      if (!vecs[v].exp_trunc) begin
        check($sformatf("vec%0d.eof_done_seen", v), eof_done_q.size(), 1);
        if (eof_done_q.size() == 1)
          check($sformatf("vec%0d.gap_cycles", v), fall - eof_done_q[0], GAP_CYC + 1);
      end
    end

    // start held across two frames: one frame per IDLE visit, SOF after the gap
    prep();
    ser_dmin = 2; ser_dmax = 2;
    w  = '{8'h3A, 8'h3B};
    w2 = '{8'h4C, 8'h4D, 8'h4E};
    model_frame(w, e1, l1, tr1);
    model_frame(w2, e2, l2, tr2);
    eall = {e1, e2};
    push_src(w);
    push_src(w2);
    start = 1'b1;
    wait_idle(1'b0, fall, ok);
    wait_idle(1'b0, fall2, ok2);
    start = 1'b0;
    check("held.done", ok & ok2, 1);
    cmp_seq("held", eall);
    if (cap_cyc_q.size() > e1.size() && eof_done_q.size() >= 1)
      check("held.sof2_delay", cap_cyc_q[e1.size()] - eof_done_q[0], GAP_CYC + 2);
    else
      check("held.sof2_seen", 0, 1);
    exp_frames += 2;
    check("held.frame_cnt", frame_cnt, exp_frames);
    repeat (6) tick();
    check("held.no_third", busy, 0);
    check("held.pops", pops, 5);

    // Upstream stalls for 10 cycles in WAIT_DATA
    prep();
    ser_dmin = 1; ser_dmax = 1;
    w = '{8'h5A, 8'hA5};
    push_src(w);
    src_stall = 1'b1;
    pulse_start();
    t = 0;
    while (data_ready !== 1'b1 && t < 100) begin tick(); t++; end
    check("stall.reached", data_ready, 1);
    hold_ok = 1'b1;
    repeat (10) begin
      if (data_ready !== 1'b1 || tx_load !== 1'b0) hold_ok = 1'b0;
      tick();
    end
    check("stall.ready_no_load", hold_ok, 1);
    check("stall.only_sof", cap_q.size(), 1);
    check("stall.no_pop", pops, 0);
    src_stall = 1'b0;
    finish_frame("stall", w, 2, 1'b0, 1'b0, fall);

    // Asynchronous reset in SEND_DATA
    prep();
    ser_dmin = 3; ser_dmax = 3;
    w = '{8'h61, 8'h62, 8'h63, 8'h64};
    push_src(w);
    pulse_start();
    t = 0;
    while (cap_q.size() < 2 && t < 200) begin tick(); t++; end
    check("arst.first_word", cap_q.size(), 2);
    tick();
    n_rst = 1'b0;
    #1;
    check("arst.busy", busy, 0);
    check("arst.tx_load", tx_load, 0);
    check("arst.tx_data", tx_data, 0);
    check("arst.data_ready", data_ready, 0);
    check("arst.truncated", truncated, 0);
    check("arst.payload_len", payload_len, 0);
    check("arst.frame_cnt", frame_cnt, 0);
    exp_frames = 0;
    repeat (2) tick();
    check("arst.no_eof", cap_q.size(), 2);
    n_rst = 1'b1;
    src_q.delete();
    tick();
    prep();
    w = '{8'h71, 8'h72};
    push_src(w);
    pulse_start();
    finish_frame("arst.next", w, 2, 1'b0, 1'b0, fall);

    // Randomised frames against the reference model
    for (int r = 0; r < 30; r++) begin
      w = {};
      t = $urandom_range(7, 1);
      for (int i = 0; i < t; i++) w.push_back(8'($urandom));
      model_frame(w, e1, len, tr);
      prep();
      ser_dmin = 1; ser_dmax = 4; ser_noise = 1'b1; src_gap_pct = 30;
      push_src(w);
      pulse_start();
      finish_frame($sformatf("rnd%0d", r), w, len, tr, 1'b1, fall);
    end
    ser_noise = 1'b0;

    check("tx_data_zero_when_idle", idle_data_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
